count_pair_checker: RTL and testbench
=====================================

COUNT_PAIR_CHECKER -- requirements
Module: count_pair_checker

Interface
REQ-001 Parameter MAX_MISS, default 3: number of consecutive mismatches that declares loss of lock.
REQ-002 Parameter ERR_W, default 8: width of the saturating error counter.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset. The clock port is named clock and the reset port is named reset.
REQ-004 clock  input  1  rising-edge clock, shared with the up/down counter pair under observation.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  the enable applied to the counter pair this cycle.
REQ-007 swap  input  1  the swap applied to the counter pair this cycle.
REQ-008 upIn  input  4  observed upCount.
REQ-009 downIn  input  4  observed downCount.
REQ-010 clearErr  input  1  synchronous clear of errCount.
REQ-011 locked  output  1  high while the TRACK state is active.
REQ-012 mismatch  output  1  one-cycle pulse per mismatching sample.
REQ-013 errCount  output  ERR_W  saturating total of mismatches.
REQ-014 state  output  2  current FSM state encoding.

Function
REQ-015 Sampling: at every rising edge the checker SHALL sample upIn, downIn, enable and swap together.
REQ-016 Prediction from a sample (u,d,en,sw) SHALL be computed as follows.
- en&sw gives (d,u).
- en&!sw gives (u+1 mod 16, d-1 mod 16).
- !en gives (u,d).
- swap is ignored when en=0.
REQ-017 Arithmetic SHALL be 4-bit modulo: 4'hF+1 gives 4'h0, and 4'h0-1 gives 4'hF. No carry or borrow is flagged.
REQ-018 The FSM SHALL have the states ACQUIRE=0, TRACK=1 and LOST=2. Encoding 3 is illegal and SHALL go to ACQUIRE.
REQ-019 ACQUIRE: the checker SHALL load the prediction from the current sample, make no comparison, and go to TRACK at the next edge.
REQ-020 TRACK with sample equal to prediction:
- reload the prediction from the sample;
- clear the miss counter;
- stay in TRACK.
REQ-021 TRACK with sample not equal to prediction:
- pulse mismatch;
- increment errCount;
- increment the miss counter;
- reload the prediction from the sample, so a single glitch costs exactly one error.
REQ-022 When the miss counter reaches MAX_MISS, the FSM SHALL go to LOST on that same edge.
REQ-023 LOST: the checker SHALL make no comparison, clear the miss counter, and go to ACQUIRE at the next edge.
REQ-024 Latency: mismatch, errCount and state SHALL be registered, visible in the cycle after the edge that sampled the offending value.
REQ-025 errCount SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-026 If clearErr and a mismatch occur in the same cycle, errCount SHALL become 1.
REQ-027 If clearErr occurs alone, errCount SHALL become 0.
REQ-028 clearErr SHALL NOT affect the FSM or the miss counter.
REQ-029 locked SHALL equal (state==TRACK).
REQ-030 mismatch SHALL never assert outside TRACK.

Reset
REQ-031 While reset is high at an edge, the checker SHALL set:
- state=ACQUIRE;
- locked=0;
- mismatch=0;
- errCount=0;
- miss counter=0;
- prediction=0.
REQ-032 Reset asserted mid-TRACK SHALL abandon the prediction. The first sample after reset deasserts is treated as an ACQUIRE sample.
REQ-033 Reset SHALL take priority over clearErr and all other inputs.

Structure
REQ-034 The shared package count_pair_pkg SHALL hold:
- COUNT_W=4;
- the state enum {ACQUIRE, TRACK, LOST};
- the default MAX_MISS.
REQ-035 The prediction rule (REQ-016/017) SHALL be a combinational sub-module named count_pair_predict, reusable by the bench's reference model.
REQ-036 Sequential logic SHALL be fully synchronous on clock. There SHALL be no latches and no asynchronous paths.

Verification
REQ-037 Lock and count: reset, then drive the sequence (0,F), (1,E), (2,D) with enable=1 and swap=0.
- locked goes to 1 two cycles after reset.
- errCount stays 0.
REQ-038 Wrap-around: with enable=1, sample (F,0).
- The next sample (0,F) SHALL be accepted with no mismatch.
REQ-039 Swap: with enable=1 and swap=1, sample (3,C).
- Then sample (C,3): no mismatch.
- Then sample (3,3): mismatch=1 for one cycle and errCount=1.
REQ-040 Loss of lock: inject 3 consecutive wrong samples while in TRACK.
- errCount=3 and state=LOST.
- Next cycle state=ACQUIRE; the cycle after, TRACK.
REQ-041 Saturation and clear:
- Force 300 mismatches; errCount holds at 255.
- Assert clearErr coincident with a mismatch; errCount=1.
- Assert clearErr alone; errCount=0.
REQ-042 Reset mid-operation: assert reset for one cycle while in TRACK with errCount=5.
- All outputs return to reset values.
- A hold sample (enable=0) afterward relocks with no error.

Source files
------------

// File: rtl/count_pair_pkg.sv
// rtl/count_pair_pkg.sv - shared constants and state type for the counter-pair checker
package count_pair_pkg;

    localparam int COUNT_W          = 4;
    localparam int DEFAULT_MAX_MISS = 3;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        LOST    = 2'd2
    } state_t;

endpackage

// File: rtl/count_pair_predict.sv
// rtl/count_pair_predict.sv - next-value prediction for one up/down counter pair sample
module count_pair_predict
    import count_pair_pkg::*;
(
    input  logic [COUNT_W-1:0] up,
    input  logic [COUNT_W-1:0] down,
    input  logic               enable,
    input  logic               swap,
    output logic [COUNT_W-1:0] next_up,
    output logic [COUNT_W-1:0] next_down
);

    // Hold when disabled; otherwise swap or count, with plain modulo wrap.
    always_comb begin
        next_up   = up;
        next_down = down;
        if (enable) begin
            if (swap) begin
                next_up   = down;
                next_down = up;
            end else begin
                next_up   = up + 1'b1;
                next_down = down - 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_pair_checker.sv
// rtl/count_pair_checker.sv - lock/track checker comparing a counter pair against its predicted behaviour
module count_pair_checker
    import count_pair_pkg::*;
#(
    parameter int MAX_MISS = DEFAULT_MAX_MISS,
    parameter int ERR_W    = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               swap,
    input  logic [COUNT_W-1:0] upIn,
    input  logic [COUNT_W-1:0] downIn,
    input  logic               clearErr,
    output logic               locked,
    output logic               mismatch,
    output logic [ERR_W-1:0]   errCount,
    output logic [1:0]         state
);

    localparam int                MISS_W     = $clog2(MAX_MISS + 1);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MAX_MISS);

    state_t              state_q, state_d;
    logic [MISS_W-1:0]   miss_q, miss_d, miss_inc;
    logic [COUNT_W-1:0]  pred_up_q, pred_up_d, pred_down_q, pred_down_d;
    logic [COUNT_W-1:0]  calc_up, calc_down;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                mismatch_q, hit_d;

    count_pair_predict u_predict (
        .up        (upIn),
        .down      (downIn),
        .enable    (enable),
        .swap      (swap),
        .next_up   (calc_up),
        .next_down (calc_down)
    );

    assign miss_inc = miss_q + 1'b1;

    // Next-state, prediction reload, miss tracking and saturating error count.
    always_comb begin
        state_d     = state_q;
        miss_d      = miss_q;
        pred_up_d   = pred_up_q;
        pred_down_d = pred_down_q;
        hit_d       = 1'b0;
        err_d       = err_q;
        case (state_q)
            ACQUIRE: begin
                pred_up_d   = calc_up;
                pred_down_d = calc_down;
                state_d     = TRACK;
            end
            TRACK: begin
                // Always reload so a single glitch costs exactly one error.
                pred_up_d   = calc_up;
                pred_down_d = calc_down;
                if (upIn == pred_up_q && downIn == pred_down_q) begin
                    miss_d = '0;
                end else begin
                    hit_d  = 1'b1;
                    miss_d = miss_inc;
                    if (miss_inc == MISS_LIMIT) begin
                        state_d = LOST;
                    end
                end
            end
            LOST: begin
                miss_d  = '0;
                state_d = ACQUIRE;
            end
            default: begin
                miss_d  = '0;
                state_d = ACQUIRE;
            end
        endcase
        if (clearErr) begin
            err_d = hit_d ? ERR_W'(1) : '0;
        end else if (hit_d && err_q != {ERR_W{1'b1}}) begin
            err_d = err_q + 1'b1;
        end
    end

    // State and datapath registers; reset overrides every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ACQUIRE;
            miss_q      <= '0;
            pred_up_q   <= '0;
            pred_down_q <= '0;
            err_q       <= '0;
            mismatch_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_q      <= miss_d;
            pred_up_q   <= pred_up_d;
            pred_down_q <= pred_down_d;
            err_q       <= err_d;
            mismatch_q  <= hit_d;
        end
    end

    assign state    = state_q;
    assign locked   = (state_q == TRACK);
    assign mismatch = mismatch_q;
    assign errCount = err_q;

endmodule

// File: tb/tb_count_pair_checker.sv
// tb/tb_count_pair_checker.sv - directed self-checking bench for count_pair_checker
module tb_count_pair_checker;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       swap = 1'b0;
    logic [3:0] upIn = 4'h0;
    logic [3:0] downIn = 4'h0;
    logic       clearErr = 1'b0;
    logic       locked;
    logic       mismatch;
    logic [7:0] errCount;
    logic [1:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    count_pair_checker dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .swap     (swap),
        .upIn     (upIn),
        .downIn   (downIn),
        .clearErr (clearErr),
        .locked   (locked),
        .mismatch (mismatch),
        .errCount (errCount),
        .state    (state)
    );

    always #5 clock = ~clock;

    task automatic step(input logic [3:0] u, input logic [3:0] d,
                        input logic en, input logic sw, input logic clr);
        upIn     = u;
        downIn   = d;
        enable   = en;
        swap     = sw;
        clearErr = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(4'h7, 4'h2, 1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        tests_run++;
        if (state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d want 0", state); end
        tests_run++;
        if (locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked got %b want 0", locked); end
        tests_run++;
        if (mismatch !== 1'b0) begin tests_failed++; $display("FAIL reset_mismatch got %b want 0", mismatch); end
        tests_run++;
        if (errCount !== 8'd0) begin tests_failed++; $display("FAIL reset_err got %0d want 0", errCount); end
    endtask

    task automatic test_lock();
        do_reset();
        step(4'h0, 4'hF, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (locked !== 1'b1) begin tests_failed++; $display("FAIL lock_locked got %b want 1", locked); end
        tests_run++;
        if (state !== 2'd1) begin tests_failed++; $display("FAIL lock_state got %0d want 1", state); end
        step(4'h1, 4'hE, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (mismatch !== 1'b0) begin tests_failed++; $display("FAIL lock_mm1 got %b want 0", mismatch); end
        step(4'h2, 4'hD, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (mismatch !== 1'b0) begin tests_failed++; $display("FAIL lock_mm2 got %b want 0", mismatch); end
        tests_run++;
        if (errCount !== 8'd0) begin tests_failed++; $display("FAIL lock_err got %0d want 0", errCount); end
        tests_run++;
        if (locked !== 1'b1) begin tests_failed++; $display("FAIL lock_still got %b want 1", locked); end
    endtask

    task automatic test_wrap();
        do_reset();
        step(4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
        step(4'h0, 4'hF, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (mismatch !== 1'b0) begin tests_failed++; $display("FAIL wrap_mm got %b want 0", mismatch); end
        tests_run++;
        if (errCount !== 8'd0) begin tests_failed++; $display("FAIL wrap_err got %0d want 0", errCount); end
        step(4'h1, 4'hE, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (mismatch !== 1'b0) begin tests_failed++; $display("FAIL wrap_mm2 got %b want 0", mismatch); end
    endtask

    task automatic test_swap();
        do_reset();
        step(4'h3, 4'hC, 1'b1, 1'b1, 1'b0);
        step(4'hC, 4'h3, 1'b1, 1'b1, 1'b0);
        tests_run++;
        if (mismatch !== 1'b0) begin tests_failed++; $display("FAIL swap_mm0 got %b want 0", mismatch); end
        step(4'h3, 4'h3, 1'b1, 1'b1, 1'b0);
        tests_run++;
        if (mismatch !== 1'b1) begin tests_failed++; $display("FAIL swap_mm1 got %b want 1", mismatch); end
        tests_run++;
        if (errCount !== 8'd1) begin tests_failed++; $display("FAIL swap_err got %0d want 1", errCount); end
        step(4'h3, 4'h3, 1'b1, 1'b1, 1'b0);
        tests_run++;
        if (mismatch !== 1'b0) begin tests_failed++; $display("FAIL swap_pulse got %b want 0", mismatch); end
        tests_run++;
        if (errCount !== 8'd1) begin tests_failed++; $display("FAIL swap_err_hold got %0d want 1", errCount); end
    endtask

    task automatic test_loss();
        do_reset();
        step(4'h5, 4'h5, 1'b0, 1'b0, 1'b0);
        step(4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (state !== 2'd1 || mismatch !== 1'b1) begin
            tests_failed++; $display("FAIL loss_first got state=%0d mm=%b want state=1 mm=1", state, mismatch);
        end
        step(4'h2, 4'h2, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (state !== 2'd1) begin tests_failed++; $display("FAIL loss_second got %0d want 1", state); end
        step(4'h3, 4'h3, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (state !== 2'd2) begin tests_failed++; $display("FAIL loss_lost got %0d want 2", state); end
        tests_run++;
        if (errCount !== 8'd3) begin tests_failed++; $display("FAIL loss_err got %0d want 3", errCount); end
        tests_run++;
        if (locked !== 1'b0) begin tests_failed++; $display("FAIL loss_locked got %b want 0", locked); end
        step(4'h9, 4'h4, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (state !== 2'd0 || mismatch !== 1'b0) begin
            tests_failed++; $display("FAIL loss_acq got state=%0d mm=%b want state=0 mm=0", state, mismatch);
        end
        step(4'h6, 4'h1, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (state !== 2'd1 || mismatch !== 1'b0) begin
            tests_failed++; $display("FAIL loss_relock got state=%0d mm=%b want state=1 mm=0", state, mismatch);
        end
        tests_run++;
        if (errCount !== 8'd3) begin tests_failed++; $display("FAIL loss_err_hold got %0d want 3", errCount); end
    endtask

    task automatic test_saturation_clear();
        logic [3:0] w;
        do_reset();
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            w = (i % 2 == 0) ? 4'hA : 4'h5;
            step(w, w, 1'b0, 1'b0, 1'b0);
            step(w, w, 1'b0, 1'b0, 1'b0);
            if (i == 254) begin
                tests_run++;
                if (errCount !== 8'd255) begin tests_failed++; $display("FAIL sat_reach got %0d want 255", errCount); end
            end
        end
        tests_run++;
        if (errCount !== 8'd255) begin tests_failed++; $display("FAIL sat_hold got %0d want 255", errCount); end
        tests_run++;
        if (state !== 2'd1) begin tests_failed++; $display("FAIL sat_state got %0d want 1", state); end
        step(4'h2, 4'h2, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (errCount !== 8'd1 || mismatch !== 1'b1) begin
            tests_failed++; $display("FAIL clr_with_mm got err=%0d mm=%b want err=1 mm=1", errCount, mismatch);
        end
        step(4'h2, 4'h2, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (errCount !== 8'd0 || mismatch !== 1'b0) begin
            tests_failed++; $display("FAIL clr_alone got err=%0d mm=%b want err=0 mm=0", errCount, mismatch);
        end
        tests_run++;
        if (state !== 2'd1) begin tests_failed++; $display("FAIL clr_state got %0d want 1", state); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] w;
        do_reset();
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            w = 4'(i + 1);
            step(w, w, 1'b0, 1'b0, 1'b0);
            step(w, w, 1'b0, 1'b0, 1'b0);
        end
        tests_run++;
        if (errCount !== 8'd5 || state !== 2'd1) begin
            tests_failed++; $display("FAIL mid_pre got err=%0d state=%0d want err=5 state=1", errCount, state);
        end
        reset = 1'b1;
        step(4'hE, 4'hE, 1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        tests_run++;
        if (state !== 2'd0 || locked !== 1'b0 || mismatch !== 1'b0 || errCount !== 8'd0) begin
            tests_failed++;
            $display("FAIL mid_reset got state=%0d locked=%b mm=%b err=%0d want 0 0 0 0", state, locked, mismatch, errCount);
        end
        step(4'h9, 4'h9, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (locked !== 1'b1 || mismatch !== 1'b0) begin
            tests_failed++; $display("FAIL mid_relock got locked=%b mm=%b want 1 0", locked, mismatch);
        end
        step(4'h9, 4'h9, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (mismatch !== 1'b0 || errCount !== 8'd0) begin
            tests_failed++; $display("FAIL mid_track got mm=%b err=%0d want 0 0", mismatch, errCount);
        end
    endtask

    initial begin
        @(posedge clock);
        #1;
        test_reset();
        test_lock();
        test_wrap();
        test_swap();
        test_loss();
        test_saturation_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
